// File: rtl/laser_beacon_tracker.sv
// Quadrature turret tracker: 4x decode, index-zeroed position, and per-revolution
// beam edge capture into a frame. Optional revolution timeout via LASER_TRACK_TIMEOUT_EN.
module laser_beacon_tracker #(
  parameter int CNT_W       = 16,
  parameter int MAX_BEACONS = 4,
  parameter int FILT_LEN    = 3,
  parameter int TIMEOUT     = 100000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 opto,
  input  logic                                 code_a,
  input  logic                                 code_b,
  input  logic                                 laser,
  output logic [CNT_W-1:0]                     pos,
  output logic [MAX_BEACONS*CNT_W-1:0]         rise_pos,
  output logic [MAX_BEACONS*CNT_W-1:0]         fall_pos,
  output logic [$clog2(MAX_BEACONS+1)-1:0]     n_beacons,
  output logic                                 overflow,
  output logic                                 frame_valid,
  output logic                                 quad_err,
  output logic                                 stale
);

  localparam int NB_W   = $clog2(MAX_BEACONS + 1);
  localparam int SLOT_W = (MAX_BEACONS > 1) ? $clog2(MAX_BEACONS) : 1;
  localparam int FC_W   = $clog2(FILT_LEN + 1);

  // Bit order of the conditioned inputs: {laser, code_b, code_a, opto}
  logic [3:0]      raw, sync1, sync2, filt, filt_p;
  logic [FC_W-1:0] fcnt [4];

  assign raw = {laser, code_b, code_a, opto};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_p <= '0;
      for (int unsigned i = 0; i < 4; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      filt_p <= filt;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (32'(fcnt[i]) == FILT_LEN - 1) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic       idx, lrise, lfall, fwd, rev, jump;
  logic [1:0] ab, ab_p;

  assign idx   = filt[0] & ~filt_p[0];
  assign lrise = filt[3] & ~filt_p[3];
  assign lfall = ~filt[3] & filt_p[3];
  assign ab    = {filt[1], filt[2]};
  assign ab_p  = {filt_p[1], filt_p[2]};
  assign jump  = (ab ^ ab_p) == 2'b11;

  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case ({ab_p, ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: rev = 1'b1;
      default: ;
    endcase
  end

  logic [CNT_W-1:0]  wrise [MAX_BEACONS];
  logic [CNT_W-1:0]  wfall [MAX_BEACONS];
  logic [NB_W-1:0]   wp, wp_eff;
  logic [SLOT_W-1:0] slot;
  logic              open, open_eff, wovf;
  logic [CNT_W-1:0]  cap;

  // An index in the same cycle as a beam edge starts the new revolution first,
  // so the edge sees an empty table and position 0.
  assign wp_eff   = idx ? '0 : wp;
  assign open_eff = open & ~idx;
  assign cap      = idx ? '0 : pos;
  assign slot     = wp_eff[SLOT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      pos         <= '0;
      rise_pos    <= '0;
      fall_pos    <= '0;
      n_beacons   <= '0;
      overflow    <= 1'b0;
      frame_valid <= 1'b0;
      quad_err    <= 1'b0;
      wp          <= '0;
      open        <= 1'b0;
      wovf        <= 1'b0;
      for (int unsigned k = 0; k < MAX_BEACONS; k++) begin
        wrise[k] <= '0;
        wfall[k] <= '0;
      end
    end else begin
      frame_valid <= idx;
      if (jump) quad_err <= 1'b1;

      if (idx)      pos <= '0;
      else if (fwd) pos <= pos + 1'b1;
      else if (rev) pos <= pos - 1'b1;

      if (idx) begin
        for (int unsigned k = 0; k < MAX_BEACONS; k++) begin
          rise_pos[k*CNT_W +: CNT_W] <= (k < 32'(wp)) ? wrise[k] : '0;
          fall_pos[k*CNT_W +: CNT_W] <= (k < 32'(wp)) ? wfall[k] : '0;
        end
        n_beacons <= wp;
        overflow  <= wovf;
        wp        <= '0;
        open      <= 1'b0;
        wovf      <= 1'b0;
      end

      if (lrise) begin
        if (int'(wp_eff) < MAX_BEACONS) begin
          wrise[slot] <= cap;
          open        <= 1'b1;
        end else begin
          wovf <= 1'b1;
        end
      end

      if (lfall && open_eff) begin
        wfall[slot] <= cap;
        open        <= 1'b0;
        wp          <= wp_eff + 1'b1;
      end
    end
  end

`ifdef LASER_TRACK_TIMEOUT_EN
  localparam int TM_W = $clog2(TIMEOUT + 1);
  logic [TM_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset)                        timer <= '0;
    else if (idx)                     timer <= '0;
    else if (32'(timer) != TIMEOUT)   timer <= timer + 1'b1;
  end

  assign stale = (32'(timer) == TIMEOUT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_laser_beacon_tracker.sv
// Self-checking bench for laser_beacon_tracker: directed and randomized sensor
// events checked against an event-level model of position and beacon frames.
module tb_laser_beacon_tracker;

  localparam int CW   = 16;
  localparam int MAXB = 4;
  localparam int FL   = 3;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset, opto, code_a, code_b, laser;
  logic [CW-1:0]      pos;
  logic [MAXB*CW-1:0] rise_pos, fall_pos;
  logic [2:0]         n_beacons;
  logic               overflow, frame_valid, quad_err, stale;

  laser_beacon_tracker #(
    .CNT_W(CW), .MAX_BEACONS(MAXB), .FILT_LEN(FL), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .reset(reset), .opto(opto), .code_a(code_a), .code_b(code_b),
    .laser(laser), .pos(pos), .rise_pos(rise_pos), .fall_pos(fall_pos),
    .n_beacons(n_beacons), .overflow(overflow), .frame_valid(frame_valid),
    .quad_err(quad_err), .stale(stale)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_pulses = 0;
  int n_index = 0;

  // Behavioural model state
  logic [CW-1:0] mpos;
  logic [1:0]    mab;
  int            mrise[$];
  int            mfall[$];
  bit            mopen, movf, mqerr;

  always @(negedge clk) if (frame_valid) fv_pulses++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hold();
    repeat (HOLD) @(negedge clk);
  endtask

  function automatic logic [1:0] gray_next(input logic [1:0] cur, input bit fw);
    logic [1:0] seq [4];
    int i;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
    i = 0;
    for (int j = 0; j < 4; j++) if (seq[j] == cur) i = j;
    return seq[(i + (fw ? 1 : 3)) % 4];
  endfunction

  task automatic step(input bit fw);
    mab    = gray_next(mab, fw);
    code_a = mab[1];
    code_b = mab[0];
    mpos   = fw ? mpos + 16'd1 : mpos - 16'd1;
    wait_hold();
    check("pos_step", pos, mpos);
  endtask

  task automatic steps(input int n, input bit fw);
    for (int i = 0; i < n; i++) step(fw);
  endtask

  task automatic beam(input bit v);
    laser = v;
    if (v) begin
      if (mfall.size() < MAXB) begin
        mrise.push_back(int'(mpos));
        mopen = 1'b1;
      end else begin
        movf = 1'b1;
      end
    end else if (mopen) begin
      mfall.push_back(int'(mpos));
      mopen = 1'b0;
    end
    wait_hold();
  endtask

  task automatic do_index(input bit with_rise);
    bit got;
    int en, dummy;
    bit eovf;
    int erise[MAXB];
    int efall[MAXB];
    got  = 1'b0;
    opto = 1'b1;
    if (with_rise) laser = 1'b1;
    n_index++;
    if (mopen) begin
      dummy = mrise.pop_back();
      mopen = 1'b0;
    end
    en   = mfall.size();
    eovf = movf;
    for (int k = 0; k < MAXB; k++) begin
      erise[k] = (k < en) ? mrise[k] : 0;
      efall[k] = (k < en) ? mfall[k] : 0;
    end
    mrise.delete();
    mfall.delete();
    movf = 1'b0;
    mpos = '0;
    if (with_rise) begin
      mrise.push_back(0);
      mopen = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (frame_valid) got = 1'b1;
    end
    check("frame_valid_seen", 64'(got), 64'd1);
    check("n_beacons", 64'(n_beacons), 64'(en));
    check("overflow", 64'(overflow), 64'(eovf));
    check("stale_at_commit", 64'(stale), 64'd0);
    check("pos_at_index", 64'(pos), 64'd0);
    for (int k = 0; k < MAXB; k++) begin
      check("rise_slot", 64'(rise_pos[k*CW +: CW]), 64'(erise[k]));
      check("fall_slot", 64'(fall_pos[k*CW +: CW]), 64'(efall[k]));
    end
    @(negedge clk);
    check("frame_valid_width", 64'(frame_valid), 64'd0);
    opto = 1'b0;
    wait_hold();
    check("pos_after_index", 64'(pos), 64'(mpos));
  endtask

  initial begin
    reset = 1'b1; opto = 1'b0; code_a = 1'b0; code_b = 1'b0; laser = 1'b0;
    mpos = '0; mab = 2'b00; mopen = 1'b0; movf = 1'b0; mqerr = 1'b0;

    // Reset defaults
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_pos", 64'(pos), 64'd0);
    check("rst_rise", rise_pos, 64'd0);
    check("rst_fall", fall_pos, 64'd0);
    check("rst_n", 64'(n_beacons), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_qerr", 64'(quad_err), 64'd0);
    check("rst_stale", 64'(stale), 64'd0);
    check("rst_no_frame", 64'(fv_pulses), 64'd0);

    // Quadrature count and wrap
    steps(5, 1'b1);
    check("fwd5", 64'(pos), 64'd5);
    steps(7, 1'b0);
    check("wrap", 64'(pos), 64'hFFFE);
    mab = ~mab;
    code_a = mab[1];
    code_b = mab[0];
    mqerr = 1'b1;
    wait_hold();
    check("jump_pos", 64'(pos), 64'(mpos));
    check("jump_qerr", 64'(quad_err), 64'(mqerr));

    // Two beacons
    do_index(1'b0);
    steps(10, 1'b1); beam(1'b1);
    steps(5, 1'b1);  beam(1'b0);
    steps(20, 1'b1); beam(1'b1);
    steps(3, 1'b1);  beam(1'b0);
    do_index(1'b0);
    check("two_n", 64'(n_beacons), 64'd2);
    check("two_r0", 64'(rise_pos[15:0]), 64'd10);
    check("two_r1", 64'(rise_pos[31:16]), 64'd35);
    check("two_f0", 64'(fall_pos[15:0]), 64'd15);
    check("two_f1", 64'(fall_pos[31:16]), 64'd38);
    check("two_hi", 64'(rise_pos[63:32]), 64'd0);

    // Overflow
    for (int p = 0; p < 5; p++) begin
      steps(2, 1'b1); beam(1'b1);
      steps(2, 1'b1); beam(1'b0);
    end
    do_index(1'b0);
    check("ovf_n", 64'(n_beacons), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);

    // Open pair at index, stray fall, rise coincident with index
    steps(50, 1'b1); beam(1'b1);
    do_index(1'b0);
    check("open_discard", 64'(n_beacons), 64'd0);
    beam(1'b0);
    laser = 1'b0;
    do_index(1'b1);
    steps(4, 1'b1); beam(1'b0);
    do_index(1'b0);
    check("coincident_n", 64'(n_beacons), 64'd1);
    check("coincident_r0", 64'(rise_pos[15:0]), 64'd0);
    check("coincident_f0", 64'(fall_pos[15:0]), 64'd4);

    // Randomized revolutions
    for (int r = 0; r < 6; r++) begin
      int nev;
      nev = int'($urandom_range(1, 14));
      for (int e = 0; e < nev; e++) begin
        int c;
        c = int'($urandom_range(0, 9));
        if (c < 6)      step(1'b1);
        else if (c < 8) step(1'b0);
        else            beam(~laser);
      end
      do_index(1'b0);
    end
    if (laser) beam(1'b0);

`ifdef LASER_TRACK_TIMEOUT_EN
    do_index(1'b0);
    repeat (975) @(negedge clk);
    check("stale_before", 64'(stale), 64'd0);
    repeat (30) @(negedge clk);
    check("stale_after", 64'(stale), 64'd1);
    do_index(1'b0);
`else
    repeat (1100) @(negedge clk);
    check("stale_tied", 64'(stale), 64'd0);
`endif

    check("qerr_sticky", 64'(quad_err), 64'(mqerr));
    check("frame_count", 64'(fv_pulses), 64'(n_index));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
